// File: rtl/phased_cache_pkg.sv
// Shared types, sizes and helpers for the phased cache controller.
package phased_cache_pkg;

    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned NUM_SETS = 4;
    localparam int unsigned IDX_W    = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TAG  = 3'd1,
        DATA = 3'd2,
        MISS = 3'd3,
        FILL = 3'd4,
        RESP = 3'd5
    } state_t;

    // One-hot of the lowest set bit; all zeros when nothing is set.
    function automatic logic [NUM_WAYS-1:0] lowest_one_hot(input logic [NUM_WAYS-1:0] v);
        logic [NUM_WAYS-1:0] r;
        r = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/repl_ptr_bank.sv
// Per-set round-robin replacement pointers, used only when a set is full.
module repl_ptr_bank
    import phased_cache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_index,
    input  logic             i_inc_en,
    output logic [IDX_W-1:0] o_ptr
);

    logic [IDX_W-1:0] r_ptr [NUM_SETS];

    assign o_ptr = r_ptr[i_index];

    // Clear all pointers on reset; bump the addressed pointer on a full-set fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this array is only four 2-bit flops, so it is reset like ordinary state;
            // a real RAM-backed array would not be reset element by element.
            for (int i = 0; i < NUM_SETS; i++) begin
                r_ptr[i] <= '0;
            end
        end else if (i_inc_en) begin
            // 2-bit add wraps 3 -> 0 on its own.
            r_ptr[i_index] <= r_ptr[i_index] + IDX_W'(1);
        end
    end

endmodule

// File: rtl/phased_cache_ctrl.sv
// Sequencing controller for a 4-way, 4-set phased cache: tag phase first,
// then a data read of the hit way only, or a memory fetch and fill on a miss.
module phased_cache_ctrl
    import phased_cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [IDX_W-1:0]    req_index,
    output logic                req_ready,
    input  logic [NUM_WAYS-1:0] way_valid,
    input  logic [NUM_WAYS-1:0] tag_match,
    output logic [IDX_W-1:0]    cur_index,
    output logic [NUM_SETS-1:0] cur_index_dec,
    output logic                tag_rd_en,
    output logic                data_rd_en,
    output logic [NUM_WAYS-1:0] data_way_sel,
    output logic [NUM_WAYS-1:0] way_load,
    output logic                mem_req,
    input  logic                mem_ack,
    output logic                resp_valid,
    output logic                resp_hit
);

    state_t              r_state;
    logic [IDX_W-1:0]    r_cur_index;
    logic [NUM_WAYS-1:0] r_victim;
    logic                r_victim_rr;
    logic                r_req_ready;
    logic                r_tag_rd_en;
    logic                r_data_rd_en;
    logic [NUM_WAYS-1:0] r_data_way_sel;
    logic [NUM_WAYS-1:0] r_way_load;
    logic                r_mem_req;
    logic                r_resp_valid;
    logic                r_resp_hit;

    logic [NUM_WAYS-1:0] w_hit_vec;
    logic [NUM_WAYS-1:0] w_hit_way;
    logic [NUM_WAYS-1:0] w_victim;
    logic                w_all_valid;
    logic [IDX_W-1:0]    w_rr_ptr;
    logic                w_rr_inc;

    assign w_hit_vec   = tag_match & way_valid;
    assign w_hit_way   = lowest_one_hot(w_hit_vec);
    assign w_all_valid = &way_valid;
    // Prefer an empty way; only a full set consumes the round-robin pointer.
    assign w_victim    = w_all_valid ? (NUM_WAYS'(1) << w_rr_ptr) : lowest_one_hot(~way_valid);
    // The pointer advances at the end of the fill cycle, and only for full-set replacement.
    assign w_rr_inc    = (r_state == FILL) && r_victim_rr;

    repl_ptr_bank u_repl_ptr_bank (
        .clk      (clk),
        .reset    (reset),
        .i_index  (r_cur_index),
        .i_inc_en (w_rr_inc),
        .o_ptr    (w_rr_ptr)
    );

    // Access sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cur_index    <= '0;
            r_victim       <= '0;
            r_victim_rr    <= 1'b0;
            r_req_ready    <= 1'b1;
            r_tag_rd_en    <= 1'b0;
            r_data_rd_en   <= 1'b0;
            r_data_way_sel <= '0;
            r_way_load     <= '0;
            r_mem_req      <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
        end else begin
            // NOTE: these defaults are non-blocking too; a later assignment in the case
            // below overrides them for this edge, which keeps every strobe single-cycle.
            r_req_ready    <= 1'b0;
            r_tag_rd_en    <= 1'b0;
            r_data_rd_en   <= 1'b0;
            r_data_way_sel <= '0;
            r_way_load     <= '0;
            r_mem_req      <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_cur_index <= req_index;
                        r_tag_rd_en <= 1'b1;
                        r_state     <= TAG;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                TAG: begin
                    if (|w_hit_vec) begin
                        r_data_rd_en   <= 1'b1;
                        r_data_way_sel <= w_hit_way;
                        r_resp_valid   <= 1'b1;
                        r_resp_hit     <= 1'b1;
                        r_state        <= DATA;
                    end else begin
                        r_victim    <= w_victim;
                        r_victim_rr <= w_all_valid;
                        r_mem_req   <= 1'b1;
                        r_state     <= MISS;
                    end
                end
                DATA: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                MISS: begin
                    if (mem_ack) begin
                        r_way_load     <= r_victim;
                        r_data_way_sel <= r_victim;
                        r_state        <= FILL;
                    end else begin
                        r_mem_req <= 1'b1;
                    end
                end
                FILL: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign cur_index     = r_cur_index;
    assign cur_index_dec = NUM_SETS'(1) << r_cur_index;
    assign tag_rd_en     = r_tag_rd_en;
    assign data_rd_en    = r_data_rd_en;
    assign data_way_sel  = r_data_way_sel;
    assign way_load      = r_way_load;
    assign mem_req       = r_mem_req;
    assign resp_valid    = r_resp_valid;
    assign resp_hit      = r_resp_hit;

endmodule

// File: doc/phased_cache_ctrl.md
Name: phased_cache_ctrl

Overview:
Sequencing controller for the 4-way, 4-set phased cache.
- Runs the tag phase first, then reads the data array only in the hit way.
- On a miss: requests the line from memory, selects a victim way, then pulses the per-way load of the valid, tag and data arrays for the latched set.
- Sits between the CPU request port, the four way slices (tag, valid, data arrays) and the memory interface.

Parameters:
- NUM_WAYS, 4, number of ways; only 4 is supported.
- NUM_SETS, 4, number of sets; only 4 is supported.
- IDX_W, 2, index width, equal to log2(NUM_SETS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_index  in  IDX_W  set index of the request.
- req_ready  out  1  controller can accept a request.
- way_valid  in  NUM_WAYS  valid bit of each way for cur_index, from the valid arrays.
- tag_match  in  NUM_WAYS  tag comparator result per way for cur_index.
- cur_index  out  IDX_W  latched index, driven to all way slices.
- cur_index_dec  out  NUM_SETS  one-hot decode of cur_index.
- tag_rd_en  out  1  tag and valid lookup phase active.
- data_rd_en  out  1  data read phase active.
- data_way_sel  out  NUM_WAYS  one-hot way enabled for data read or fill.
- way_load  out  NUM_WAYS  one-hot fill strobe to valid/tag/data load inputs.
- mem_req  out  1  line fetch request to memory.
- mem_ack  in  1  memory returns the line; single-cycle pulse.
- resp_valid  out  1  response strobe to the CPU.
- resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = serviced miss.

Behaviour:
- Reset: state = IDLE, all round-robin pointers = 0, cur_index = 0, all outputs 0 except req_ready = 1. Reset mid-operation aborts the access and drops mem_req the same cycle; no way_load is issued.
- States: IDLE, TAG, DATA, MISS, FILL, RESP. Outputs are Moore, decoded from state plus registered cur_index, hit_way and victim.
- IDLE: req_ready = 1. If req_valid, latch req_index into cur_index and go to TAG.
- TAG: tag_rd_en = 1.
  - hit_vec = tag_match & way_valid.
  - Any bit set: hit_way = lowest set bit, go to DATA.
  - No bit set: miss, latch victim, go to MISS.
  - Multiple hit bits: lowest index wins, no error signalled.
- Victim selection:
  - Lowest-index way with way_valid = 0.
  - If all 4 ways are valid: rr_ptr[cur_index].
- DATA: data_rd_en = 1, data_way_sel = hit_way, resp_valid = 1, resp_hit = 1. Go to IDLE.
- Hit latency: accepted at edge N; resp_valid high during cycle N+2.
- MISS: mem_req = 1, held until mem_ack; wait is unbounded. On mem_ack go to FILL.
- mem_ack outside MISS is ignored.
- FILL: way_load = victim and data_way_sel = victim, each for exactly 1 cycle. If the victim came from rr_ptr, rr_ptr[cur_index] increments mod 4, wrapping 3 -> 0. Go to RESP.
- RESP: resp_valid = 1, resp_hit = 0. Go to IDLE.
- Miss latency: 3 cycles plus the memory wait.
- req_valid outside IDLE is ignored (req_ready = 0). No queueing, one access in flight.
- rr_ptr is updated only on a replacement of a full set; fills into invalid ways leave it unchanged.
- cur_index and cur_index_dec are stable from TAG through RESP.

Decomposition:
- Shared package phased_cache_pkg holds:
  - the state enum,
  - NUM_WAYS, NUM_SETS, IDX_W,
  - a lowest-set-bit one-hot priority function, reused by hit and victim selection.
- Natural sub-module: repl_ptr_bank. It holds the 4 × 2-bit round-robin pointers, with a read port indexed by cur_index, an increment-enable input and synchronous reset.

Test Plan:
1. Reset, then req index 2, way_valid = 0000 → TAG, MISS (mem_req = 1). mem_ack after 5 cycles → way_load = 0001 one cycle, then resp_valid = 1, resp_hit = 0. rr_ptr[2] stays 0.
2. Req index 1, way_valid = 1111, tag_match = 0100 → resp_valid = 1, resp_hit = 1, data_way_sel = 0100 exactly 2 cycles after acceptance. No mem_req.
3. Index 3, way_valid = 1111, tag_match = 0000, repeated 5 misses → way_load sequence 0001, 0010, 0100, 1000, 0001 (pointer wrap).
4. way_valid = 1011, tag_match = 0000 → victim way_load = 0100; rr_ptr unchanged.
5. Assert reset while in MISS with mem_req high → next cycle mem_req = 0, req_ready = 1, no way_load. A later mem_ack is ignored.
6. Hold req_valid during a miss with index 0 changing to 2 → cur_index stays at the original value; the second request is accepted only when req_ready returns to 1.
